// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional
// two-entry skid buffer. Entries are a payload word plus a control field;
// whenever nothing is presented the control field reads as CTRL_NOP so a
// downstream stage sees a clean bubble.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              out_valid_q;
    logic [1:0]        occupancy_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // in_ready: registered with the skid buffer, combinational without it
    generate
        if (SKID) begin : g_skid_ready
            logic in_ready_q;

            // Ready for the next cycle is known from the next state; the
            // register resets low so ready rises on the first edge after reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_d != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_comb_ready
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
        end
    endgenerate

    // State register and all held entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_NOP;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            out_valid_q <= (state_d != ST_EMPTY);
            occupancy_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    // Without a skid register in_fire implies out_fire here,
                    // so this branch only matters when SKID is set.
                    if (SKID) begin
                        state_d = ST_TWO;
                    end
                end else if (!in_fire && out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Datapath loads for main and skid registers
    always_comb begin
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                end
            endcase
        end else begin
            skid_ctrl_d = CTRL_NOP;
        end
        // A bubble must carry the NOP control; payload keeps its last value.
        if (state_d == ST_EMPTY) begin
            main_ctrl_d = CTRL_NOP;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus.
// Each instance has a queue of expected entries; stimulus pushes accepted
// entries, a monitor pops on every downstream transfer and compares.
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam logic [CW-1:0] NOP = 8'h5A;

    typedef logic [CW+DW-1:0] ent_t;   // {ctrl, data}

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_ready;

    // index 1: SKID=1 instance, index 0: SKID=0 instance
    logic          irdy [2];
    logic          ovld [2];
    logic [DW-1:0] odat [2];
    logic [CW-1:0] octl [2];
    logic [1:0]    occ  [2];

    ent_t exp_q [2][$];

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1'b1)) u_skid1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]), .out_ctrl(octl[1]),
        .occupancy(occ[1])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1'b0)) u_skid0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]), .out_ctrl(octl[0]),
        .occupancy(occ[0])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // State visible after the last edge must match the expected queue
    task automatic check_state();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("occupancy[%0d]", i), 32'(occ[i]), 32'(exp_q[i].size()));
            chk($sformatf("out_valid[%0d]", i), 32'(ovld[i]), 32'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0) begin
                chk($sformatf("head[%0d]", i), 32'({octl[i], odat[i]}), 32'(exp_q[i][0]));
            end else begin
                chk($sformatf("bubble_ctrl[%0d]", i), 32'(octl[i]), 32'(NOP));
            end
        end
    endtask

    // One clock cycle of stimulus plus model update
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic fl, input logic ordy);
        logic exp_rdy [2];
        @(negedge clk);
        check_state();
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_rdy[1] = (exp_q[1].size() < 2);
        exp_rdy[0] = (exp_q[0].size() == 0) || ordy;
        chk("in_ready[1]", 32'(irdy[1]), 32'(exp_rdy[1]));
        chk("in_ready[0]", 32'(irdy[0]), 32'(exp_rdy[0]));
        #2;  // the monitor has popped any downstream transfer by now
        for (int i = 0; i < 2; i++) begin
            if (fl) begin
                exp_q[i].delete();
            end else if (v && exp_rdy[i]) begin
                exp_q[i].push_back({c, d});
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_valid[%0d]", i), 32'(ovld[i]), 32'd0);
            chk($sformatf("rst_occ[%0d]", i), 32'(occ[i]), 32'd0);
            chk($sformatf("rst_data[%0d]", i), 32'(odat[i]), 32'd0);
            chk($sformatf("rst_ctrl[%0d]", i), 32'(octl[i]), 32'(NOP));
            exp_q[i].delete();
        end
        chk("rst_in_ready[1]", 32'(irdy[1]), 32'd0);
        chk("rst_in_ready[0]", 32'(irdy[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: pops and compares on every downstream transfer
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (!reset && ovld[i] && out_ready) begin
                    if (exp_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out[%0d]: got %h expected none", i, {octl[i], odat[i]});
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("scoreboard[%0d]", i), 32'({octl[i], odat[i]}), 32'(e));
                        if (verbose) begin
                            $display("xfer inst=%0d data=%h ctrl=%h", i, odat[i], octl[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // Streaming 1..4 at full throughput
        for (int k = 1; k <= 4; k++) step(1'b1, DW'(k), CW'(8'h10 + k), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("stream_occ[1]", 32'(occ[1]), 32'd1);
        chk("stream_data[1]", 32'(odat[1]), 32'h4);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Backpressure fills the skid buffer
        step(1'b1, 16'h000A, 8'h21, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 8'h22, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("bp_occ[1]", 32'(occ[1]), 32'd2);
        chk("bp_in_ready[1]", 32'(irdy[1]), 32'd0);
        chk("bp_data[1]", 32'(odat[1]), 32'h000A);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("bp_data2[1]", 32'(odat[1]), 32'h000B);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("bp_empty[1]", 32'(occ[1]), 32'd0);

        // Flush with a coincident input that must be discarded
        step(1'b1, 16'h0001, 8'h31, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 8'h32, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 8'h33, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("flush_valid[1]", 32'(ovld[1]), 32'd0);
        chk("flush_ctrl[1]", 32'(octl[1]), 32'(NOP));
        chk("flush_occ[1]", 32'(occ[1]), 32'd0);
        chk("flush_valid[0]", 32'(ovld[0]), 32'd0);

        // Combinational ready without a skid register
        step(1'b1, 16'h0005, 8'h41, 1'b0, 1'b0);
        step(1'b1, 16'h0006, 8'h42, 1'b0, 1'b0);
        chk("noskid_stall_rdy[0]", 32'(irdy[0]), 32'd0);
        for (int k = 6; k <= 9; k++) begin
            step(1'b1, DW'(k), CW'(8'h40 + k), 1'b0, 1'b1);
            chk("noskid_go_rdy[0]", 32'(irdy[0]), 32'd1);
        end
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Asynchronous reset with two entries held
        step(1'b1, 16'h00D1, 8'h51, 1'b0, 1'b0);
        step(1'b1, 16'h00D2, 8'h52, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("pre_rst_occ[1]", 32'(occ[1]), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("async_valid[1]", 32'(ovld[1]), 32'd0);
        chk("async_ctrl[1]", 32'(octl[1]), 32'(NOP));
        chk("async_data[1]", 32'(odat[1]), 32'd0);
        chk("async_occ[1]", 32'(occ[1]), 32'd0);
        chk("async_valid[0]", 32'(ovld[0]), 32'd0);
        do_reset();

        // Random valid/ready/flush
        verbose = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
        end
        verbose = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drain_occ[1]", 32'(occ[1]), 32'd0);
        chk("drain_occ[0]", 32'(occ[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, meaning payload width in bits.
REQ-002 Parameter CTRL_W, default 8, meaning control-field width in bits.
REQ-003 Parameter CTRL_NOP, default 0 (CTRL_W bits), meaning control value of a bubble.
REQ-004 Parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_data  input  DATA_W  upstream payload (ALU result, store data, destination register, ...).
REQ-010 in_ctrl  input  CTRL_W  upstream control bits (reg_write, mem_read, mem_write, mem_to_reg, ...).
REQ-011 flush  input  1  synchronous squash of all held entries.
REQ-012 out_valid  output  1  held entry presented downstream.
REQ-013 out_ready  input  1  downstream consumes the presented entry.
REQ-014 out_data  output  DATA_W  presented payload.
REQ-015 out_ctrl  output  CTRL_W  presented control; equals CTRL_NOP whenever out_valid=0.
REQ-016 occupancy  output  2  number of held entries, 0..2.

Function
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; all outputs are registered except in_ready when SKID=0.
REQ-018 State machine with states EMPTY, ONE, TWO; out_valid=1 in ONE and TWO; occupancy = 0/1/2 respectively.
REQ-019 EMPTY: in_fire -> ONE with main register loaded from in_data/in_ctrl; otherwise stay.
REQ-020 ONE: in_fire & out_fire -> ONE with main reloaded; in_fire only -> TWO with skid register loaded; out_fire only -> EMPTY; neither -> hold.
REQ-021 TWO: out_fire -> ONE with main loaded from skid; otherwise hold; no input is accepted in TWO.
REQ-022 SKID=1: in_ready = 1 in EMPTY and ONE, 0 in TWO, driven from a register.
REQ-023 SKID=0: state never reaches TWO; in_ready = (state==EMPTY) | out_ready, combinational.
REQ-024 Latency: an entry accepted in cycle N is presented on out_* in cycle N+1 when the stage was EMPTY or out_fire occurred in N.
REQ-025 Order: entries leave strictly in acceptance order; no entry is duplicated or dropped except by flush.
REQ-026 Whenever the next state is EMPTY, main ctrl is loaded with CTRL_NOP; main data holds its last value.
REQ-027 flush has priority over all transfers: next state EMPTY, main and skid ctrl <= CTRL_NOP, any in_fire in the same cycle is discarded.
REQ-028 out_fire coinciding with flush counts as consumed by downstream; the flushed entries are the remaining ones.
REQ-029 Held registers and state are unchanged while in_fire=0, out_fire=0 and flush=0 (stall).

Reset
REQ-030 reset=1 asynchronously forces state EMPTY, out_valid=0, occupancy=0, out_data=0, skid data=0, out_ctrl=CTRL_NOP, skid ctrl=CTRL_NOP.
REQ-031 With SKID=1, in_ready is 1 from the first clock edge after reset deassertion; with SKID=0 it is 1 combinationally after reset.
REQ-032 reset asserted mid-operation discards all held entries immediately, without waiting for a clock edge.

Verification
REQ-033 Streaming: in_valid=1 with data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles one cycle later, in_ready stays 1, occupancy 1.
REQ-034 Backpressure (SKID=1): out_ready=0 while sending 0xA,0xB -> occupancy 2, in_ready=0, out_data=0xA; out_ready=1 for two cycles -> 0xA then 0xB, occupancy 0.
REQ-035 Flush: hold 2 entries, assert flush with in_valid=1 data 0xC -> next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy 0, 0xC never appears.
REQ-036 SKID=0: out_ready=0 with one entry held -> in_ready=0 in the same cycle; toggle out_ready=1 -> in_ready=1 combinationally and throughput one entry per cycle.
REQ-037 Async reset: assert reset between clock edges while occupancy=2 -> out_valid=0, out_ctrl=CTRL_NOP, out_data=0 before the next edge.
REQ-038 Random valid/ready/flush for 10000 cycles -> scoreboard shows in-order delivery, no loss except flushed entries, out_ctrl=CTRL_NOP whenever out_valid=0.
